// File: rtl/seg_pkg.sv
// Shared types and segment encodings for the multiplexed 7-segment driver.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h7E;

    // Active-low {a,b,c,d,e,f,g} patterns for digits 0..9
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
        7'h24, 7'h20, 7'h0F, 7'h00, 7'h04
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] s;
        s = SEG_BLANK;
        if (nibble < 4'd10) begin
            s = SEG_DIGITS[nibble];
        end
        return s;
    endfunction

endpackage

// File: rtl/bcd_dd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
module bcd_dd_conv
    import seg_pkg::*;
#(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [IN_W-1:0]         bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd_out
);

    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    conv_state_t      state_q;
    logic [IN_W-1:0]  shreg_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [BCD_W-1:0] bcd_adj;

    // Add-3 correction applied to every nibble before each shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // COMMIT spans two cycles: pulse done, then release busy on the hand-off edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        shreg_q <= bin_in;
                        bcd_q   <= '0;
                        cnt_q   <= CNT_W'(IN_W - 1);
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    {bcd_q, shreg_q} <= {bcd_adj, shreg_q} << 1;
                    cnt_q            <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit common-anode 7-segment scan driver with sequential BCD conversion.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned IN_W        = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     bin_in,
    input  logic                load,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int unsigned BCD_DIGITS = (IN_W * 302) / 1000 + 1;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned DISP_W     = 4 * N_DIGITS;
    localparam int unsigned PRE_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                     conv_done;
    logic [BCD_W-1:0]         bcd;
    logic [DISP_W+BCD_W-1:0]  bcd_ext;
    logic [DISP_W-1:0]        disp_d;
    logic                     ovf_d;
    logic [DISP_W-1:0]        disp_q;
    logic                     ovf_q;
    logic                     done_q;
    logic [PRE_W-1:0]         pre_q;
    logic [IDX_W-1:0]         idx_q;
    logic [N_DIGITS-1:0]      an_q;
    logic [6:0]               seg_q;
    logic [6:0]               seg_c;
    logic [N_DIGITS-1:0]      blank_mask;

    bcd_dd_conv #(
        .IN_W      (IN_W),
        .BCD_DIGITS(BCD_DIGITS)
    ) u_conv (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (conv_done),
        .bcd_out(bcd)
    );

    // Zero-extend so the display slice and the overflow slice are always in range
    always_comb begin
        bcd_ext = {DISP_W'(0), bcd};
        disp_d  = bcd_ext[DISP_W-1:0];
        ovf_d   = |bcd_ext[DISP_W +: BCD_W];
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] blank_d;
    logic [N_DIGITS-1:0] blank_q;
    logic                lead;

    // Digits above the most significant nonzero digit blank; digit 0 never does
    always_comb begin
        blank_d = '0;
        lead    = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            lead       = lead & (disp_d[4*i +: 4] == 4'd0);
            blank_d[i] = lead;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (conv_done) begin
            blank_q <= blank_d;
        end
    end

    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        seg_c = seg_decode(disp_q[4*idx_q +: 4]);
        if (blank_mask[idx_q]) begin
            seg_c = SEG_BLANK;
        end
        if (ovf_q) begin
            seg_c = SEG_DASH;
        end
    end

    // an and seg update together on each prescaler wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            pre_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
        end else begin
            done_q <= conv_done;
            if (conv_done) begin
                disp_q <= disp_d;
                ovf_q  <= ovf_d;
            end
            if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                an_q  <= ~(N_DIGITS'(1) << idx_q);
                seg_q <= seg_c;
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: a 4-digit and a 2-digit driver checked against an arithmetic display model.
module tb_seg_scan_driver;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bin_in = '0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy, done, ovf;
    logic [7:0] bin2 = '0;
    logic       load2 = 1'b0;
    logic [6:0] seg2;
    logic [1:0] an2;
    logic       busy2, done2, ovf2;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    always #5 clk = ~clk;

    seg_scan_driver #(.N_DIGITS(4), .IN_W(8), .REFRESH_DIV(R)) dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
        .seg(seg), .an(an), .busy(busy), .done(done), .ovf(ovf)
    );

    seg_scan_driver #(.N_DIGITS(2), .IN_W(8), .REFRESH_DIV(R)) dut2 (
        .clk(clk), .rst(rst), .bin_in(bin2), .load(load2),
        .seg(seg2), .an(an2), .busy(busy2), .done(done2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Expected pattern of digit i for value v on an nd-digit display
    function automatic logic [6:0] exp_seg(input int v, input int i, input int nd);
        if (v >= pow10(nd)) return 7'h7E;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i > 0 && v < pow10(i)) return 7'h7F;
`endif
        return seg_tbl[(v / pow10(i)) % 10];
    endfunction

    task automatic scan_check(input int sel, input int v);
        int         nd;
        logic [6:0] seen [4];
        bit         got [4];
        bit         bad, hit;
        logic [3:0] a;
        logic [6:0] s;
        nd  = sel ? 2 : 4;
        bad = 0;
        for (int i = 0; i < 4; i++) begin seen[i] = '0; got[i] = 0; end
        repeat (R + 1) @(negedge clk);
        for (int c = 0; c < nd * R; c++) begin
            @(negedge clk);
            a   = sel ? {2'b11, an2} : an;
            s   = sel ? seg2 : seg;
            hit = 0;
            for (int i = 0; i < nd; i++) begin
                if (a == ~(4'(1) << i)) begin seen[i] = s; got[i] = 1; hit = 1; end
            end
            if (!hit) bad = 1;
        end
        chk($sformatf("onehot_an v=%0d", v), 32'(bad), 32'd0);
        for (int i = 0; i < nd; i++) begin
            chk($sformatf("seg dut%0d v=%0d digit%0d", sel, v, i),
                got[i] ? {25'd0, seen[i]} : 32'hFF, {25'd0, exp_seg(v, i, nd)});
        end
    endtask

    task automatic run_conv(input int sel, input int v, input bit poke_busy);
        int lat;
        lat = -1;
        @(negedge clk);
        if (sel != 0) begin bin2 = 8'(v); load2 = 1'b1; end
        else          begin bin_in = 8'(v); load = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        load = 1'b0; load2 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (poke_busy && n == 2) begin
                chk("busy_mid_conv", 32'(busy), 32'd1);
                bin_in = 8'd99; load = 1'b1;
            end
            if (poke_busy && n == 3) load = 1'b0;
            if ((sel != 0) ? done2 : done) begin lat = n; break; end
        end
        chk($sformatf("done_latency v=%0d", v), 32'(lat), 32'd10);
        chk($sformatf("busy_at_done v=%0d", v), 32'((sel != 0) ? busy2 : busy), 32'd0);
        chk($sformatf("ovf v=%0d", v), 32'((sel != 0) ? ovf2 : ovf),
            32'(v >= pow10((sel != 0) ? 2 : 4)));
        @(negedge clk);
        chk($sformatf("done_pulse_width v=%0d", v), 32'((sel != 0) ? done2 : done), 32'd0);
    endtask

    initial begin
        int         chg_t [5];
        logic [3:0] chg_v [5];
        logic [3:0] exp_an [5];
        logic [3:0] prev;
        int         nchg, first, second, v;

        exp_an = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset seg", 32'(seg), 32'h7F);
        chk("reset an", 32'(an), 32'hF);
        chk("reset busy/done/ovf", {29'd0, busy, done, ovf}, 32'd0);

        // Scan rotation from reset: first wrap after R edges, then every R
        prev = an; nchg = 0;
        for (int c = 2; c <= 60 && nchg < 5; c++) begin
            @(negedge clk);
            if (an !== prev) begin chg_t[nchg] = c; chg_v[nchg] = an; nchg++; prev = an; end
        end
        chk("scan change count", 32'(nchg), 32'd5);
        for (int k = 0; k < nchg; k++) begin
            chk($sformatf("scan an #%0d", k), 32'(chg_v[k]), 32'(exp_an[k]));
            chk($sformatf("scan time #%0d", k), 32'(chg_t[k]), 32'(R + R * k));
        end

        run_conv(0, 237, 1'b1);
        scan_check(0, 237);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk); bin_in = 8'd200; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        chk("busy before async reset", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async reset seg", 32'(seg), 32'h7F);
        chk("async reset an", 32'(an), 32'hF);
        chk("async reset busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        scan_check(0, 0);

        run_conv(0, 0, 1'b0);
        scan_check(0, 0);

        // Back-to-back conversions with load held high
        @(negedge clk); bin_in = 8'd255; load = 1'b1;
        @(posedge clk);
        @(negedge clk); bin_in = 8'd1;
        first = -1; second = -1;
        for (int n = 1; n <= 40 && second < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (first < 0) first = n;
                else begin second = n; load = 1'b0; end
            end
        end
        load = 1'b0;
        chk("b2b first done", 32'(first), 32'd10);
        chk("b2b period", 32'(second - first), 32'd11);
        scan_check(0, 1);

        run_conv(1, 150, 1'b0);
        scan_check(1, 150);
        run_conv(1, 42, 1'b0);
        scan_check(1, 42);

        for (int k = 0; k < 4; k++) begin
            v = int'($urandom_range(255));
            run_conv(0, v, 1'b0);
            scan_check(0, v);
            v = int'($urandom_range(255));
            run_conv(1, v, 1'b0);
            scan_check(1, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
